pmu_wkup_filter: RTL
====================

# pmu_wkup_filter

PMU wake-up event filter, directly downstream of the PMU level synchronizers. Takes already-synchronized event levels in the `i_oclk` domain and filters each bit against glitches with a programmable stability count. It latches masked rising edges into sticky pending bits. It raises a four-phase req/ack wake-up request toward the PMU power-state controller.

## Interface
Parameters:
- `W`, 4, number of event lines.
- `FILT_W`, 4, width of the filter counter and of `i_filt_cyc`.
- `DEFVAL`, 0, reset value of the filtered level registers.

Ports:
- `i_oclk`  in  1  PMU clock.
- `i_orstn`  in  1  reset, asynchronous, active-low.
- `i_evt`  in  W  synchronized event levels; already in the `i_oclk` domain, no further synchronization here.
- `i_mask`  in  W  1 = bit may set pending.
- `i_filt_cyc`  in  FILT_W  stability count N; quasi-static.
- `i_clr`  in  W  write-1-to-clear pulse for pending bits.
- `i_wkup_ack`  in  1  acknowledge from the PMU controller.
- `o_pend`  out  W  sticky pending bits.
- `o_wkup_req`  out  1  wake-up request.

## Operation
- Per bit `i`, registers:
  - `flt[i]`, the filtered level;
  - `flt_d[i]`, the previous filtered level;
  - `cnt[i]`, FILT_W bits.
- Filter update at each edge:
  - If `i_evt[i]==flt[i]`, then `cnt<=0`.
  - Else if `cnt==i_filt_cyc`, then `flt<=i_evt`, `cnt<=0`.
  - Else `cnt<=cnt+1`.
  - Any return to agreement restarts the count, so a glitch shorter than N+1 cycles never changes `flt`.
- `flt_d<=flt` every cycle. `rise[i] = flt[i] & ~flt_d[i] & i_mask[i]`.
- Pending update: `pend <= (pend & ~i_clr) | rise`. Set wins over a simultaneous clear of the same bit.
- Mask gates only new sets. Pending bits already set stay set when their mask bit is cleared.
- FSM states and transitions:
  - IDLE (req=0): goes to REQ when `|pend`.
  - REQ (req=1): goes to ACKED when `i_wkup_ack=1`.
  - ACKED (req=0): goes to IDLE when `i_wkup_ack=0`.
  - Encoding is 2-bit binary; the unused code returns to IDLE.
- `i_wkup_ack` while in IDLE is ignored.
- Clearing all pending bits while in REQ does not withdraw `req`; the handshake completes normally.
- If pending is still nonzero on return to IDLE, a new request is raised.
- Falling edges of `flt` are filtered identically but never set pending.

## Timing
- Reset values:
  - `flt=DEFVAL`, `flt_d=DEFVAL`, `cnt=0`;
  - `o_pend=0`, `o_wkup_req=0`, FSM in IDLE.
- If `flt` resets high (`DEFVAL=1`), no `rise` is produced by reset release.
- Latency, with `i_evt` first sampled high at edge k and held:
  - `flt` high after edge k+N;
  - `o_pend` high after edge k+N+1;
  - `o_wkup_req` high after edge k+N+2.
- `o_wkup_req` falls on the edge after `i_wkup_ack` is sampled high.
- `o_pend` and `o_wkup_req` are registered outputs with no combinational path from inputs.
- Counter saturation is impossible: `cnt` never exceeds `i_filt_cyc`.
- If `i_filt_cyc` is changed mid-count to a value below `cnt`, the count runs on and wraps to 0 at 2^FILT_W, so `flt` updates at most 2^FILT_W+1 cycles after the change. Software changes `i_filt_cyc` only with events masked.
- Asynchronous reset mid-handshake returns to IDLE with `req=0` immediately. The controller must tolerate an abandoned request.

## Configuration
- Macro `PMU_WKUP_FILT_EN`.
- Defined: per-bit filter counters as described.
- Undefined:
  - counters are removed and `i_filt_cyc` is ignored;
  - `flt<=i_evt` every cycle, i.e. the N=0 timing;
  - all other behaviour is unchanged.

## Test plan
- Reset/DEFVAL:
  - reset with `DEFVAL=0` -> `o_pend=0`, `o_wkup_req=0`;
  - with `DEFVAL=1` and `i_evt=1` held through reset release -> no pend, no req.
- Glitch reject: `i_filt_cyc=3`, `i_evt[0]` high for 3 cycles then low -> `o_pend` stays 0. A 4-cycle pulse -> `o_pend[0]=1` 5 edges after the first sample and `o_wkup_req=1` one edge later.
- Handshake:
  - with pend set, `req=1`;
  - ack=1 -> `req=0` on the next edge;
  - ack held -> req stays 0;
  - ack=0 -> IDLE, and `req=1` again on the next edge because pend is still set;
  - `i_clr=0x1` then empties pend -> no further req.
- Set/clear collision: `rise[2]` and `i_clr[2]` in the same cycle -> `o_pend[2]=1`. `i_clr[1]` alone -> `o_pend[1]=0` with other bits unchanged.
- Mask: `i_mask=0xE`, edge on bit 0 -> no pend. Bit 3 pending, then `i_mask[3]` cleared -> `o_pend[3]` stays 1.
- Macro off: `i_filt_cyc=0xF`, 1-cycle pulse on bit 1 -> `o_pend[1]=1` two edges after the sample.

Source files
------------

// File: rtl/pmu_wkup_filter_if.sv
// pmu_wkup_filter_if: event/config inputs, pending bits and req/ack wake-up handshake
interface pmu_wkup_filter_if #(
  parameter int W = 4,
  parameter int FILT_W = 4
);
  logic [W-1:0] i_evt, i_mask, i_clr, o_pend;
  logic [FILT_W-1:0] i_filt_cyc;
  logic i_wkup_ack, o_wkup_req;
  modport master (output i_evt, i_mask, i_filt_cyc, i_clr, i_wkup_ack, input o_pend, o_wkup_req);
  modport slave (input i_evt, i_mask, i_filt_cyc, i_clr, i_wkup_ack, output o_pend, o_wkup_req);
endinterface

// File: rtl/pmu_wkup_filter.sv
// pmu_wkup_filter: glitch filter, sticky pending and req/ack wake-up; PMU_WKUP_FILT_EN enables per-bit stability counters
module pmu_wkup_filter #(
  parameter int W = 4,
  parameter int FILT_W = 4,
  parameter int DEFVAL = 0
) (
  input logic i_oclk,
  input logic i_orstn,
  pmu_wkup_filter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, ACKED = 2'd2} state_t;
  localparam logic [W-1:0] FLT_RST = (DEFVAL != 0) ? '1 : '0;
  logic [W-1:0] flt, flt_d, pend, rise;
  state_t state_q, state_d;
`ifdef PMU_WKUP_FILT_EN
  logic [W-1:0][FILT_W-1:0] cnt;
  // any return to agreement restarts the count, so short glitches never reach flt
  always_ff @(posedge i_oclk or negedge i_orstn)
    if (!i_orstn) begin
      flt <= FLT_RST;
      cnt <= '0;
    end else begin
      for (int i = 0; i < W; i++)
        if (bus.i_evt[i] == flt[i]) cnt[i] <= '0;
        else if (cnt[i] == bus.i_filt_cyc) begin
          flt[i] <= bus.i_evt[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + FILT_W'(1);
    end
`else
  logic unused_filt;
  assign unused_filt = ^bus.i_filt_cyc;
  always_ff @(posedge i_oclk or negedge i_orstn)
    if (!i_orstn) flt <= FLT_RST;
    else flt <= bus.i_evt;
`endif
  assign rise = flt & ~flt_d & bus.i_mask;
  always_ff @(posedge i_oclk or negedge i_orstn)
    if (!i_orstn) begin
      flt_d <= FLT_RST;
      pend <= '0;
      state_q <= IDLE;
    end else begin
      flt_d <= flt;
      pend <= (pend & ~bus.i_clr) | rise;
      state_q <= state_d;
    end
  always_comb begin
    state_d = IDLE;
    if (state_q == IDLE) state_d = |pend ? REQ : IDLE;
    else if (state_q == REQ) state_d = bus.i_wkup_ack ? ACKED : REQ;
    else if (state_q == ACKED) state_d = bus.i_wkup_ack ? ACKED : IDLE;
  end
  assign bus.o_pend = pend;
  assign bus.o_wkup_req = state_q == REQ;
endmodule
